// File: rtl/div_pkg.sv
// Shared definitions for the signed restoring divider: default operand width
// and the controller state encoding.
package div_pkg;

   localparam int DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_FINISH
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the result if non-negative.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH-1:0] shifted;
   logic [WIDTH:0]   diff;
   logic             borrow;

   assign shifted = {rem[WIDTH-2:0], quo[WIDTH-1]};
   assign diff    = {1'b0, shifted} - {1'b0, divisor};
   // A set remainder MSB means the shifted value already exceeds any divisor.
   assign borrow  = diff[WIDTH] & ~rem[WIDTH-1];

   assign rem_next = borrow ? shifted : diff[WIDTH-1:0];
   assign quo_next = {quo[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed divider: magnitudes are divided with one restoring step
// per cycle, then sign-corrected into hi (remainder) and lo (quotient).
module div_unit
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH);

   div_state_t       state_reg, state_next;
   logic [CW-1:0]    count_reg;
   logic [WIDTH-1:0] rem_reg, quo_reg, div_reg;
   logic             neg_q_reg, neg_r_reg;
   logic [WIDTH-1:0] hi_reg, lo_reg;
   logic             done_reg, div_zero_reg;

   logic [WIDTH-1:0] abs_a, abs_b;
   logic [WIDTH-1:0] rem_step, quo_step;
   logic [WIDTH-1:0] q_final, r_final;
   logic             b_zero;

   assign b_zero  = (b == '0);
   assign abs_a   = a[WIDTH-1] ? -a : a;
   assign abs_b   = b[WIDTH-1] ? -b : b;
   assign q_final = neg_q_reg ? -quo_reg : quo_reg;
   assign r_final = neg_r_reg ? -rem_reg : rem_reg;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_reg),
      .quo      (quo_reg),
      .divisor  (div_reg),
      .rem_next (rem_step),
      .quo_next (quo_step)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (start && !b_zero) state_next = ST_CALC;
         ST_CALC:   if (count_reg == '0)  state_next = ST_FINISH;
         ST_FINISH: state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_reg    <= '0;
         rem_reg      <= '0;
         quo_reg      <= '0;
         div_reg      <= '0;
         neg_q_reg    <= 1'b0;
         neg_r_reg    <= 1'b0;
         hi_reg       <= '0;
         lo_reg       <= '0;
         done_reg     <= 1'b0;
         div_zero_reg <= 1'b0;
      end else begin
         done_reg     <= 1'b0;
         div_zero_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start && b_zero) begin
                  div_zero_reg <= 1'b1;
               end else if (start) begin
                  // The dividend magnitude is shifted out of quo_reg one bit per step.
                  rem_reg   <= '0;
                  quo_reg   <= abs_a;
                  div_reg   <= abs_b;
                  neg_r_reg <= a[WIDTH-1];
                  neg_q_reg <= a[WIDTH-1] ^ b[WIDTH-1];
                  count_reg <= CW'(WIDTH - 1);
               end
            end
            ST_CALC: begin
               rem_reg   <= rem_step;
               quo_reg   <= quo_step;
               count_reg <= count_reg - 1'b1;
            end
            ST_FINISH: begin
               hi_reg   <= r_final;
               lo_reg   <= q_final;
               done_reg <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign hi       = hi_reg;
   assign lo       = lo_reg;
   assign busy     = (state_reg != ST_IDLE);
   assign done     = done_reg;
   assign div_zero = div_zero_reg;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 clock  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  divCtrl request pulse; sampled only in IDLE.
REQ-005 a  input  WIDTH  dividend (register A value), signed two's complement.
REQ-006 b  input  WIDTH  divisor (register B value), signed two's complement.
REQ-007 hi  output  WIDTH  remainder, feeds DivCtrl HI mux.
REQ-008 lo  output  WIDTH  quotient, feeds MultCtrl LO mux.
REQ-009 busy  output  1  high while an operation is in progress (CALC or FINISH).
REQ-010 done  output  1  one-cycle pulse marking hi/lo updated.
REQ-011 div_zero  output  1  one-cycle pulse marking divide-by-zero exception to the control unit.

Function
REQ-012 FSM states: IDLE, CALC, FINISH; reset state IDLE.
REQ-013 IDLE, start=1, b!=0: latch |a|, |b|, sign(a), sign(a)^sign(b); clear partial remainder; iteration counter = WIDTH-1; go to CALC.
REQ-014 IDLE, start=1, b==0: stay IDLE; assert div_zero for exactly the next cycle; hi/lo unchanged; done not asserted.
REQ-015 CALC: one restoring-division step per cycle (shift remainder/quotient left 1, trial subtract divisor, keep if non-negative, set quotient bit); WIDTH cycles total; counter 0 -> FINISH.
REQ-016 FINISH: apply sign correction; write hi/lo; assert done for one cycle; return to IDLE.
REQ-017 Latency: start sampled at edge N -> done high and hi/lo valid in the cycle after edge N+WIDTH+1 (N+33 for WIDTH=32).
REQ-018 Quotient truncates toward zero; negated when dividend and divisor signs differ.
REQ-019 Remainder takes the sign of the dividend; |remainder| < |divisor|.
REQ-020 Overflow case a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0, no exception flag (magnitude arithmetic wraps mod 2^WIDTH).
REQ-021 start while busy is ignored; in-flight operand latches not disturbed.
REQ-022 hi/lo hold their last value at all times other than the FINISH update edge; a and b may change freely after the start edge.
REQ-023 busy low in IDLE, high from the edge after start acceptance through the FINISH cycle inclusive.
REQ-024 done and div_zero never high in the same cycle.

Reset
REQ-025 reset=1 at a rising edge: state IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0; counter and internal latches cleared.
REQ-026 Reset mid-operation aborts the operation; no done is produced for it.
REQ-027 reset and start high on the same edge: reset wins; the request is dropped.

Structure
REQ-028 Shared package div_pkg holds the FSM state enumeration and the WIDTH default constant.
REQ-029 Optional combinational sub-module div_step (one shift/trial-subtract iteration) instantiated once inside div_unit; no other hierarchy.
REQ-030 No multi-cycle paths; the single WIDTH-bit subtractor is the critical path.

Verification
REQ-031 a=7, b=2, start pulse -> done at N+33; lo=3, hi=1.
REQ-032 a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 Preload hi=1, lo=3; then a=5, b=0 -> div_zero pulse at N+1; done never asserted; hi=1, lo=3 unchanged; busy stays 0.
REQ-034 a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
REQ-035 Start a=100, b=7; reset asserted 10 cycles later -> next cycle all outputs 0, state IDLE; done absent; new start a=100, b=7 then gives lo=14, hi=2.
REQ-036 Start a=9, b=3; second start a=1, b=1 at N+5 -> second request ignored; done once at N+33 with lo=3, hi=0.
